du_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single distribution unit (DU) between NUM_REQ requesters, e.g. the pipeline DU-instruction port and a prefetch/debug port. It serialises requests, issues one start pulse per transaction, waits for DU completion with a timeout, and returns the 256-bit result. It generates per-requester stalls so each requester freezes until its own acknowledge arrives.

---
 rtl/du_pkg.sv | 15 +
 rtl/du_rr_picker.sv | 28 ++
 rtl/du_arbiter.sv | 134 +++++++++++++
 tb/tb_du_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/du_pkg.sv
// Shared definitions for the distribution unit and its request arbiter.
// State encoding and word widths are common to both sides of the DU interface.
package du_pkg;

  localparam int DU_DATA_W = 256;
  localparam int DU_RS1_W  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } du_state_e;

endpackage

// File: rtl/du_rr_picker.sv
// Combinational round-robin select: first requester at or above rr_ptr, wrapping.
module du_rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic               any,
  output logic [PTR_W-1:0]   gnt_id
);

  // Scan from the farthest offset down so the nearest set bit is written last.
  always_comb begin
    int w_idx;
    w_idx  = 0;
    any    = 1'b0;
    gnt_id = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_idx = int'(rr_ptr) + i;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (req[PTR_W'(w_idx)]) begin
        any    = 1'b1;
        gnt_id = PTR_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/du_arbiter.sv
// Round-robin arbiter/sequencer sharing one distribution unit between requesters,
// with a bounded wait for DU completion and per-requester stall generation.
module du_arbiter
  import du_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = DU_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [DU_RS1_W*NUM_REQ-1:0] req_rs1,
  output logic [NUM_REQ-1:0]         stall,
  output logic [NUM_REQ-1:0]         ack,
  output logic [NUM_REQ-1:0]         err,
  output logic [DATA_W-1:0]          result,
  output logic                       busy,
  output logic                       du_start,
  output logic [DU_RS1_W-1:0]        du_rs1,
  input  logic                       du_done,
  input  logic [DATA_W-1:0]          du_result
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  du_state_e              r_state;
  du_state_e              w_state_next;
  logic [PTR_W-1:0]       r_rr_ptr;
  logic [PTR_W-1:0]       r_gnt_id;
  logic [CNT_W-1:0]       r_cnt;
  logic [NUM_REQ-1:0]     r_ack;
  logic [NUM_REQ-1:0]     r_err;
  logic [DATA_W-1:0]      r_result;
  logic                   r_du_start;
  logic [DU_RS1_W-1:0]    r_du_rs1;
  logic                   w_any;
  logic [PTR_W-1:0]       w_gnt_id;
  logic [DU_RS1_W-1:0]    w_sel_rs1;
  logic [NUM_REQ-1:0]     w_gnt_onehot;
  logic                   w_wait_end;

  du_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req    (req),
    .rr_ptr (r_rr_ptr),
    .any    (w_any),
    .gnt_id (w_gnt_id)
  );

  always_comb begin
    w_sel_rs1 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_id == PTR_W'(i)) w_sel_rs1 = req_rs1[DU_RS1_W*i +: DU_RS1_W];
    end
  end

  always_comb begin
    w_gnt_onehot           = '0;
    w_gnt_onehot[r_gnt_id] = 1'b1;
  end

  assign w_wait_end = du_done || (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_next = ISSUE;
      ISSUE:   w_state_next = WAIT;
      WAIT:    if (w_wait_end) w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Pulses (start/ack/err) are produced on the edge entering the state that owns them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= '0;
      r_gnt_id   <= '0;
      r_cnt      <= '0;
      r_ack      <= '0;
      r_err      <= '0;
      r_result   <= '0;
      r_du_start <= 1'b0;
      r_du_rs1   <= '0;
    end else begin
      r_du_start <= 1'b0;
      r_ack      <= '0;
      r_err      <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gnt_id   <= w_gnt_id;
            r_du_rs1   <= w_sel_rs1;
            r_du_start <= 1'b1;
          end
        end
        ISSUE: r_cnt <= CNT_W'(TIMEOUT);
        WAIT: begin
          if (du_done) begin
            r_result <= du_result;
            r_ack    <= w_gnt_onehot;
          end else if (r_cnt == '0) begin
            r_result <= '0;
            r_ack    <= w_gnt_onehot;
            r_err    <= w_gnt_onehot;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        RESP: r_rr_ptr <= (r_gnt_id == PTR_W'(NUM_REQ - 1)) ? '0 : r_gnt_id + PTR_W'(1);
        default: ;
      endcase
    end
  end

  assign stall    = req & ~r_ack;
  assign ack      = r_ack;
  assign err      = r_err;
  assign result   = r_result;
  assign busy     = (r_state != IDLE);
  assign du_start = r_du_start;
  assign du_rs1   = r_du_rs1;

endmodule

// File: tb/tb_du_arbiter.sv
// Self-checking bench for du_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin model.
module tb_du_arbiter;

  localparam int N   = 2;
  localparam int DW  = 256;
  localparam int TMO = 4;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [32*N-1:0] req_rs1;
  logic [N-1:0]    stall;
  logic [N-1:0]    ack;
  logic [N-1:0]    err;
  logic [DW-1:0]   result;
  logic            busy;
  logic            du_start;
  logic [31:0]     du_rs1;
  logic            du_done;
  logic [DW-1:0]   du_result;

  int checks = 0;
  int errors = 0;
  int modelPtr = 0;

  du_arbiter #(
    .NUM_REQ (N),
    .DATA_W  (DW),
    .TIMEOUT (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_rs1   (req_rs1),
    .stall     (stall),
    .ack       (ack),
    .err       (err),
    .result    (result),
    .busy      (busy),
    .du_start  (du_start),
    .du_rs1    (du_rs1),
    .du_done   (du_done),
    .du_result (du_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raise requests; a newly raised requester gets its operand at the same time.
  task automatic applyStimulus(input logic [N-1:0] raise, input logic [32*N-1:0] rs1Vals);
    for (int i = 0; i < N; i++) begin
      if (raise[i] && !req[i]) req_rs1[32*i +: 32] = rs1Vals[32*i +: 32];
    end
    req = req | raise;
  endtask

  function automatic int modelPick(input logic [N-1:0] r, input int ptr);
    for (int o = 0; o < N; o++) begin
      if (r[(ptr + o) % N]) return (ptr + o) % N;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] randWord();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[32*i +: 32] = $urandom;
    return w;
  endfunction

  // Runs one transaction starting in an IDLE cycle (called just after a rising edge).
  // doneK = WAIT cycle carrying du_done; 0 = DU never answers.
  task automatic runTxn(input string tag, input int doneK, input logic [DW-1:0] data);
    int win, cyc, expAck;
    bit seen, expErr;
    logic [N-1:0] onehot;
    logic [DW-1:0] expRes;
    logic [31:0] expRs1;
    win    = modelPick(req, modelPtr);
    onehot = '0;
    if (win >= 0) onehot[win] = 1'b1;
    expRs1 = (win >= 0) ? req_rs1[32*win +: 32] : 32'h0;
    expErr = !(doneK >= 1 && doneK <= TMO + 1);
    expAck = expErr ? TMO + 3 : 2 + doneK;
    expRes = expErr ? '0 : data;
    du_result = data;
    @(negedge clk);
    checkOutput({tag, "_idle_busy"}, busy, 0);
    checkOutput({tag, "_idle_stall"}, stall, req);
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < TMO + 12) begin
      @(posedge clk); #1;
      cyc++;
      du_done = (doneK > 0 && cyc == 1 + doneK);
      @(negedge clk);
      if (cyc == 1) begin
        checkOutput({tag, "_start"}, du_start, 1);
        checkOutput({tag, "_rs1"}, du_rs1, expRs1);
        checkOutput({tag, "_stall_hold"}, stall[win], 1);
      end
      if (cyc == 2) checkOutput({tag, "_start_pulse"}, du_start, 0);
      if (ack != '0) begin
        seen = 1;
        checkOutput({tag, "_ack_cycle"}, cyc, expAck);
        checkOutput({tag, "_ack"}, ack, onehot);
        checkOutput({tag, "_err"}, err, expErr ? onehot : '0);
        checkOutput({tag, "_result"}, result, expRes);
        checkOutput({tag, "_stall_ack"}, stall, req & ~onehot);
      end
    end
    checkOutput({tag, "_ack_seen"}, seen, 1);
    @(posedge clk); #1;
    du_done = 1'b0;
    if (win >= 0) req[win] = 1'b0;
    modelPtr = (win + 1) % N;
  endtask

  initial begin
    logic [DW-1:0] pattern;
    logic [N-1:0]  raise;
    int            k;
    rst_n     = 1'b0;
    req       = 2'b10;
    req_rs1   = '0;
    du_done   = 1'b0;
    du_result = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ack", ack, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_start", du_start, 0);
    checkOutput("rst_rs1", du_rs1, 0);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_stall", stall, 2'b10);
    req   = '0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] single request");
    for (int i = 0; i < DW / 8; i++) pattern[8*i +: 8] = 8'hAA;
    applyStimulus(2'b01, {32'h0, 32'h00001234});
    runTxn("single", 2, pattern);

    $display("[TB] contention");
    applyStimulus(2'b11, {32'hB0B0_0001, 32'hA0A0_0000});
    runTxn("cont0", 1, randWord());
    runTxn("cont1", 1, randWord());
    applyStimulus(2'b11, {32'hB0B0_0011, 32'hA0A0_0010});
    runTxn("cont_again0", 1, randWord());
    runTxn("cont_again1", 1, randWord());

    $display("[TB] fairness");
    for (int t = 0; t < 4; t++) begin
      applyStimulus(2'b11, {$urandom, $urandom});
      runTxn($sformatf("fair%0d", t), 1 + (t % 2), randWord());
    end
    runTxn("fair_drain", 1, randWord());

    $display("[TB] timeout");
    applyStimulus(2'b01, {32'h0, 32'h0000_7777});
    runTxn("timeout", 0, randWord());
    du_done = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("late_done_ack%0d", c), ack, 0);
      checkOutput($sformatf("late_done_busy%0d", c), busy, 0);
      @(posedge clk); #1;
      du_done = 1'b0;
    end

    $display("[TB] coincident done and expiry");
    applyStimulus(2'b10, {32'h0000_5555, 32'h0});
    runTxn("coincident", TMO + 1, randWord());

    $display("[TB] reset mid-wait");
    applyStimulus(2'b01, {32'h0, 32'h0000_0101});
    runTxn("pre_reset", 1, randWord());
    applyStimulus(2'b10, {32'h0000_0202, 32'h0});
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    req   = '0;
    #1;
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_ack", ack, 0);
    checkOutput("mid_rst_rs1", du_rs1, 0);
    checkOutput("mid_rst_result", result, 0);
    checkOutput("mid_rst_stall", stall, 0);
    @(posedge clk); #1;
    rst_n   = 1'b1;
    du_done = 1'b1;
    modelPtr = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("post_rst_ack%0d", c), ack, 0);
      checkOutput($sformatf("post_rst_err%0d", c), err, 0);
      @(posedge clk); #1;
      du_done = 1'b0;
    end
    applyStimulus(2'b11, {32'h0000_0303, 32'h0000_0404});
    runTxn("post_rst0", 2, randWord());
    runTxn("post_rst1", 3, randWord());

    $display("[TB] randomized traffic");
    for (int t = 0; t < 24; t++) begin
      raise = N'($urandom_range(0, (1 << N) - 1));
      if ((req | raise) == '0) raise[$urandom_range(0, N - 1)] = 1'b1;
      applyStimulus(raise, {$urandom, $urandom});
      k = $urandom_range(1, TMO + 2);
      runTxn($sformatf("rand%0d", t), k, randWord());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
